axi_pkt_loopback_responder: RTL and testbench
=============================================

Name: axi_pkt_loopback_responder

Overview:
- Far-end responder for the 64B user-IO AXI-stream link; one side of this link is the user-IO AXI converter.
- Accepts 8-beat × 64-bit packets on an AXI-stream slave and checks their framing.
- Buffers good packets store-and-forward, then retransmits them as 8-beat packets on an AXI-stream master.
- Used as the link-partner model and as the loopback target for userio link bring-up.

Parameters:
- PKT_DEPTH, 4, number of 64B packet slots in the buffer; power of 2, ≥ 2.
- XOR_MASK, 64'h0, value XORed onto every transmitted data beat. A nonzero value proves the data passed through the responder.

Ports:
- clk  input  1  block clock; all logic is in this domain.
- reset_n  input  1  synchronous, active-low reset.
- i_stat_chan_up  input  1  link up; low means flush.
- i_axi_rx_tvalid  input  1  rx beat valid.
- i_axi_rx_tdata  input  64  rx beat data.
- i_axi_rx_tkeep  input  8  rx byte enables.
- i_axi_rx_tlast  input  1  rx end of packet.
- o_axi_rx_tready  output  1  rx ready.
- o_axi_tx_tvalid  output  1  tx beat valid.
- o_axi_tx_tdata  output  64  tx beat data.
- o_axi_tx_tkeep  output  8  tx byte enables.
- o_axi_tx_tlast  output  1  tx end of packet.
- i_axi_tx_tready  input  1  tx ready.
- o_pkt_ok_cnt  output  16  packets committed to the buffer; saturates at 16'hFFFF.
- o_pkt_err_cnt  output  16  packets dropped; saturates at 16'hFFFF.

Behaviour:
- Reset (reset_n low at a clk edge):
  - Both FSMs go to IDLE; buffer and packet count are emptied; counters are 0.
  - o_axi_rx_tready=0, o_axi_tx_tvalid=0, tdata/tkeep/tlast=0.
- Flush (i_stat_chan_up low): same effect as reset, except counters hold their values. Flush mid-packet discards any partial rx packet and any in-flight tx packet, and the error count is not incremented.
- Storage: PKT_DEPTH×8 entries of 64 bits.
  - Committed-packet count pkt_cnt runs 0..PKT_DEPTH.
  - rx slot pointer, tx slot pointer and 3-bit beat counters wrap modulo their size.
- A beat is accepted when tvalid & tready at a clk edge.
- o_axi_rx_tready = chan_up & ((pkt_cnt < PKT_DEPTH) | rx_state==RX_DROP), registered-free combinational.
- RX FSM:
  - RX_IDLE → RX_PKT on the first accepted beat. Beat 0 is written to the slot, and bad_keep is set if tkeep≠8'hFF.
  - RX_PKT: each accepted beat is written at the beat counter position and the counter increments.
    - tlast on beat 7 with no bad_keep → commit: pkt_cnt+1, rx slot+1, o_pkt_ok_cnt+1, next state RX_IDLE.
    - tlast on beat 7 with bad_keep set → drop: o_pkt_err_cnt+1, slot not advanced, next state RX_IDLE.
    - tlast on beats 0–6 → drop.
    - Beat 7 without tlast → RX_DROP.
  - RX_DROP: tready=1; beats are discarded until an accepted tlast. On that tlast, o_pkt_err_cnt+1 and next state RX_IDLE.
- TX FSM:
  - TX_IDLE → TX_SEND when pkt_cnt>0. The first tx beat is valid the cycle after the commit edge, giving a minimum latency of 1 cycle from the accepted rx tlast.
  - TX_SEND:
    - o_axi_tx_tvalid=1, tdata=mem[slot][beat]^XOR_MASK, tkeep=8'hFF, tlast=(beat==7).
    - Outputs are held stable while tready is low; the beat advances only on tready.
    - When beat 7 is accepted: release the slot (tx slot+1, pkt_cnt−1), next state TX_IDLE. Back-to-back packets therefore have one idle cycle between them.
  - When tvalid=0, tdata, tkeep and tlast are 0.
- Simultaneous commit and release in the same cycle: pkt_cnt is unchanged.
- Full buffer (pkt_cnt==PKT_DEPTH): tready=0 in RX_IDLE. This cannot occur in RX_PKT, because the slot was free when the packet started.
- Counters saturate and never wrap.

Test Plan:
- Single packet:
  - Stimulus: after reset, send beats 64'h0..64'h7 with tlast on beat 7, tkeep=FF, tx_tready=1.
  - Required: tx emits 0..7 with tlast on the 8th beat, first tx beat 1 cycle after the rx tlast; ok_cnt=1, err_cnt=0.
- Backpressure and full:
  - Stimulus: PKT_DEPTH=4, tx_tready=0, send 5 packets.
  - Required: tready drops after the 4th commit; releasing tx_tready drains packets in order; the 5th packet is then accepted; tx data is held stable while stalled; ok_cnt=5.
- Framing errors:
  - Stimulus: send a packet with tlast on beat 3, then a 10-beat packet with tlast on beat 9, then a good packet.
  - Required: err_cnt=2, ok_cnt=1, and only the good packet appears on tx.
- Bad tkeep:
  - Stimulus: send a packet with tkeep=8'h0F on beat 2.
  - Required: packet dropped, err_cnt=1, nothing transmitted.
- XOR and flush:
  - Stimulus 1: XOR_MASK=64'hFFFF_FFFF_FFFF_FFFF, send 0..7. Required: tx emits the bitwise inverse.
  - Stimulus 2: drop i_stat_chan_up mid-rx and mid-tx. Required: tvalid/tready go to 0 the next cycle, buffer is empty, counters unchanged; after the link is back up a new packet passes.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 for 1 cycle while 2 packets are buffered.
  - Required: all outputs 0 and counters 0 after the edge; no stale packets are emitted afterwards.

Source files
------------

// File: rtl/axi_pkt_loopback_responder.sv
// Far-end loopback responder for the 64B user-IO AXI-stream link.
// Receives 8-beat x 64-bit packets, drops badly framed ones, stores good
// packets store-and-forward and retransmits them XORed with XOR_MASK.
module axi_pkt_loopback_responder #(
  parameter int unsigned PKT_DEPTH = 4,
  parameter logic [63:0] XOR_MASK  = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_stat_chan_up,
  input  logic        i_axi_rx_tvalid,
  input  logic [63:0] i_axi_rx_tdata,
  input  logic [7:0]  i_axi_rx_tkeep,
  input  logic        i_axi_rx_tlast,
  output logic        o_axi_rx_tready,
  output logic        o_axi_tx_tvalid,
  output logic [63:0] o_axi_tx_tdata,
  output logic [7:0]  o_axi_tx_tkeep,
  output logic        o_axi_tx_tlast,
  input  logic        i_axi_tx_tready,
  output logic [15:0] o_pkt_ok_cnt,
  output logic [15:0] o_pkt_err_cnt
);

  localparam int unsigned SW = $clog2(PKT_DEPTH);
  localparam int unsigned CW = SW + 1;
  localparam int unsigned AW = SW + 3;
  localparam logic [SW-1:0] SLOT_ONE = SW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(PKT_DEPTH);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_PKT = 2'd1, RX_DROP = 2'd2} rx_state_e;
  typedef enum logic       {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

  // Saturating increment for the packet statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc = v;
    else               sat_inc = v + 16'd1;
  endfunction

  rx_state_e     rx_state_q, rx_state_d;
  logic [2:0]    rx_beat_q, rx_beat_d;
  logic [SW-1:0] rx_slot_q, rx_slot_d;
  logic          bad_keep_q, bad_keep_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0]   ok_cnt_q, ok_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [2:0]    tx_beat_q, tx_beat_d;
  logic [SW-1:0] tx_slot_q, tx_slot_d;
  logic          tx_valid_q, tx_valid_d;
  logic [63:0]   tx_data_q, tx_data_d;
  logic [7:0]    tx_keep_q, tx_keep_d;
  logic          tx_last_q, tx_last_d;
  logic [63:0]   mem_q [0:PKT_DEPTH*8-1];

  logic          rx_ready_s, rx_acc_s, keep_bad_s;
  logic          mem_we_s, commit_s, drop_s, release_s;
  logic [AW-1:0] mem_waddr_s;
  logic [2:0]    tx_beat_nxt_s;

  // The drop state must keep draining even when the buffer is full.
  assign rx_ready_s = reset_n & i_stat_chan_up &
                      ((pkt_cnt_q < DEPTH_C) | (rx_state_q == RX_DROP));
  assign rx_acc_s   = i_axi_rx_tvalid & rx_ready_s;
  assign keep_bad_s = (i_axi_rx_tkeep != 8'hFF);

  // RX framing FSM: decides write position, commit or drop of each packet.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_beat_d   = rx_beat_q;
    bad_keep_d  = bad_keep_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = {rx_slot_q, rx_beat_q};
    commit_s    = 1'b0;
    drop_s      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_acc_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = {rx_slot_q, 3'd0};
          if (i_axi_rx_tlast) begin
            drop_s = 1'b1;
          end else begin
            rx_state_d = RX_PKT;
            rx_beat_d  = 3'd1;
            bad_keep_d = keep_bad_s;
          end
        end else begin
          rx_beat_d = 3'd0;
        end
      end
      RX_PKT: begin
        if (rx_acc_s) begin
          mem_we_s = 1'b1;
          if (i_axi_rx_tlast) begin
            if ((rx_beat_q == 3'd7) && !(bad_keep_q | keep_bad_s)) commit_s = 1'b1;
            else                                                   drop_s   = 1'b1;
            rx_state_d = RX_IDLE;
            rx_beat_d  = 3'd0;
          end else if (rx_beat_q == 3'd7) begin
            rx_state_d = RX_DROP;
            rx_beat_d  = 3'd0;
          end else begin
            rx_beat_d  = rx_beat_q + 3'd1;
            bad_keep_d = bad_keep_q | keep_bad_s;
          end
        end else begin
          rx_beat_d = rx_beat_q;
        end
      end
      RX_DROP: begin
        if (rx_acc_s && i_axi_rx_tlast) begin
          drop_s     = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DROP;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_beat_d  = 3'd0;
      end
    endcase
  end

  // Slot pointer, occupancy and statistics next-state.
  always_comb begin
    rx_slot_d = commit_s ? (rx_slot_q + SLOT_ONE) : rx_slot_q;
    ok_cnt_d  = commit_s ? sat_inc(ok_cnt_q) : ok_cnt_q;
    err_cnt_d = drop_s ? sat_inc(err_cnt_q) : err_cnt_q;
    case ({commit_s, release_s})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // TX FSM: loads the next registered beat from the buffer on each handshake.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_beat_d     = tx_beat_q;
    tx_slot_d     = tx_slot_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    tx_keep_d     = tx_keep_q;
    tx_last_d     = tx_last_q;
    release_s     = 1'b0;
    tx_beat_nxt_s = tx_beat_q + 3'd1;
    case (tx_state_q)
      TX_IDLE: begin
        if (pkt_cnt_q != {CW{1'b0}}) begin
          tx_state_d = TX_SEND;
          tx_beat_d  = 3'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = mem_q[{tx_slot_q, 3'd0}] ^ XOR_MASK;
          tx_keep_d  = 8'hFF;
          tx_last_d  = 1'b0;
        end else begin
          tx_valid_d = 1'b0;
          tx_data_d  = 64'd0;
          tx_keep_d  = 8'h00;
          tx_last_d  = 1'b0;
        end
      end
      TX_SEND: begin
        if (i_axi_tx_tready) begin
          if (tx_beat_q == 3'd7) begin
            release_s  = 1'b1;
            tx_slot_d  = tx_slot_q + SLOT_ONE;
            tx_state_d = TX_IDLE;
            tx_beat_d  = 3'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = 64'd0;
            tx_keep_d  = 8'h00;
            tx_last_d  = 1'b0;
          end else begin
            tx_beat_d = tx_beat_nxt_s;
            tx_data_d = mem_q[{tx_slot_q, tx_beat_nxt_s}] ^ XOR_MASK;
            tx_last_d = (tx_beat_nxt_s == 3'd7);
          end
        end else begin
          tx_state_d = TX_SEND;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 64'd0;
        tx_keep_d  = 8'h00;
        tx_last_d  = 1'b0;
      end
    endcase
  end

  // Control state: reset clears everything, link-down flush keeps the counters.
  always_ff @(posedge clk) begin
    if (!reset_n || !i_stat_chan_up) begin
      rx_state_q <= RX_IDLE;
      rx_beat_q  <= 3'd0;
      rx_slot_q  <= {SW{1'b0}};
      bad_keep_q <= 1'b0;
      pkt_cnt_q  <= {CW{1'b0}};
      tx_state_q <= TX_IDLE;
      tx_beat_q  <= 3'd0;
      tx_slot_q  <= {SW{1'b0}};
      tx_valid_q <= 1'b0;
      tx_data_q  <= 64'd0;
      tx_keep_q  <= 8'h00;
      tx_last_q  <= 1'b0;
      ok_cnt_q   <= reset_n ? ok_cnt_q : 16'd0;
      err_cnt_q  <= reset_n ? err_cnt_q : 16'd0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_beat_q  <= rx_beat_d;
      rx_slot_q  <= rx_slot_d;
      bad_keep_q <= bad_keep_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tx_state_q <= tx_state_d;
      tx_beat_q  <= tx_beat_d;
      tx_slot_q  <= tx_slot_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_keep_q  <= tx_keep_d;
      tx_last_q  <= tx_last_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Packet buffer: contents need no reset, occupancy is tracked by pkt_cnt_q.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= i_axi_rx_tdata;
    end
  end

  assign o_axi_rx_tready = rx_ready_s;
  assign o_axi_tx_tvalid = tx_valid_q;
  assign o_axi_tx_tdata  = tx_data_q;
  assign o_axi_tx_tkeep  = tx_keep_q;
  assign o_axi_tx_tlast  = tx_last_q;
  assign o_pkt_ok_cnt    = ok_cnt_q;
  assign o_pkt_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axi_pkt_loopback_responder.sv
// Self-checking bench for axi_pkt_loopback_responder: directed and random
// packets, a packet-level reference model (good = exactly 8 beats, all tkeep
// FF) and a tx monitor comparing every transmitted beat in order.
module tb_axi_pkt_loopback_responder;

  localparam int          DEPTH = 4;
  localparam logic [63:0] MASK  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset_n;
  logic        i_stat_chan_up;
  logic        i_axi_rx_tvalid;
  logic [63:0] i_axi_rx_tdata;
  logic [7:0]  i_axi_rx_tkeep;
  logic        i_axi_rx_tlast;
  logic        o_axi_rx_tready;
  logic        o_axi_tx_tvalid;
  logic [63:0] o_axi_tx_tdata;
  logic [7:0]  o_axi_tx_tkeep;
  logic        o_axi_tx_tlast;
  logic        i_axi_tx_tready;
  logic [15:0] o_pkt_ok_cnt;
  logic [15:0] o_pkt_err_cnt;

  axi_pkt_loopback_responder #(.PKT_DEPTH(DEPTH), .XOR_MASK(MASK)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_stat_chan_up  (i_stat_chan_up),
    .i_axi_rx_tvalid (i_axi_rx_tvalid),
    .i_axi_rx_tdata  (i_axi_rx_tdata),
    .i_axi_rx_tkeep  (i_axi_rx_tkeep),
    .i_axi_rx_tlast  (i_axi_rx_tlast),
    .o_axi_rx_tready (o_axi_rx_tready),
    .o_axi_tx_tvalid (o_axi_tx_tvalid),
    .o_axi_tx_tdata  (o_axi_tx_tdata),
    .o_axi_tx_tkeep  (o_axi_tx_tkeep),
    .o_axi_tx_tlast  (o_axi_tx_tlast),
    .i_axi_tx_tready (i_axi_tx_tready),
    .o_pkt_ok_cnt    (o_pkt_ok_cnt),
    .o_pkt_err_cnt   (o_pkt_err_cnt)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          ok_m   = 0;
  int          err_m  = 0;
  int          tx_mode = 1;   // 0: tx_tready low, 1: high, 2: random
  logic [63:0] exp_q[$];      // expected tx beats, in order, already masked
  bit          stall_prev;
  logic [63:0] d_prev;
  logic        l_prev;
  int          tx_seen;
  logic [63:0] e_beat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // tx_tready driver, following the mode chosen by the main sequence
  initial begin
    i_axi_tx_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_mode == 0)      i_axi_tx_tready = 1'b0;
      else if (tx_mode == 1) i_axi_tx_tready = 1'b1;
      else                   i_axi_tx_tready = 1'($urandom_range(0, 1));
    end
  end

  // tx monitor: samples just before each rising edge
  initial begin
    stall_prev = 1'b0;
    tx_seen    = 0;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n && i_stat_chan_up) begin
        if (stall_prev) begin
          check("hold_valid", 64'(o_axi_tx_tvalid), 64'd1);
          check("hold_data", o_axi_tx_tdata, d_prev);
          check("hold_last", 64'(o_axi_tx_tlast), 64'(l_prev));
        end
        if (!o_axi_tx_tvalid) begin
          check("idle_data", o_axi_tx_tdata, 64'd0);
          check("idle_ctl", {55'd0, o_axi_tx_tkeep, o_axi_tx_tlast}, 64'd0);
        end else if (i_axi_tx_tready) begin
          if (exp_q.size() == 0) begin
            check("tx_unexpected", 64'(exp_q.size()), 64'd1);
          end else begin
            e_beat = exp_q.pop_front();
            check("tx_data", o_axi_tx_tdata, e_beat);
            check("tx_last", 64'(o_axi_tx_tlast), 64'(tx_seen % 8 == 7));
            check("tx_keep", 64'(o_axi_tx_tkeep), 64'hFF);
            tx_seen++;
          end
        end
        stall_prev = o_axi_tx_tvalid && !i_axi_tx_tready;
        d_prev     = o_axi_tx_tdata;
        l_prev     = o_axi_tx_tlast;
      end else begin
        stall_prev = 1'b0;
        tx_seen    = 0;
      end
    end
  end

  // Send one rx packet; the model then classifies it from the framing rules.
  task automatic send_pkt(input int nbeats, input int bad_beat, input bit with_last, input bit seq);
    logic [63:0] d[16];
    int w;
    for (int i = 0; i < nbeats; i++) d[i] = seq ? 64'(i) : {$urandom, $urandom};
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      i_axi_rx_tvalid = 1'b1;
      i_axi_rx_tdata  = d[i];
      i_axi_rx_tkeep  = (i == bad_beat) ? 8'h0F : 8'hFF;
      i_axi_rx_tlast  = with_last && (i == nbeats - 1);
      #1;
      w = 0;
      while (!o_axi_rx_tready && w < 300) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (w >= 300) check("rx_ready_timeout", 64'(w), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    i_axi_rx_tvalid = 1'b0;
    i_axi_rx_tlast  = 1'b0;
    i_axi_rx_tdata  = 64'd0;
    i_axi_rx_tkeep  = 8'h00;
    if (with_last) begin
      if (nbeats == 8 && bad_beat < 0) begin
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i] ^ MASK);
        ok_m++;
      end else begin
        err_m++;
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int w = 0;
    while (exp_q.size() != 0 && w < bound) begin
      @(negedge clk);
      w++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ok"}, 64'(o_pkt_ok_cnt), 64'(ok_m));
    check({tag, "_err"}, 64'(o_pkt_err_cnt), 64'(err_m));
  endtask

  initial begin
    int kind;
    reset_n         = 1'b0;
    i_stat_chan_up  = 1'b1;
    i_axi_rx_tvalid = 1'b0;
    i_axi_rx_tdata  = 64'd0;
    i_axi_rx_tkeep  = 8'h00;
    i_axi_rx_tlast  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", 64'(o_axi_tx_tvalid), 64'd0);
    check("rst_tready", 64'(o_axi_rx_tready), 64'd0);
    check("rst_tdata", o_axi_tx_tdata, 64'd0);
    check_counts("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_tready", 64'(o_axi_rx_tready), 64'd1);

    // single packet 0..7, one-cycle latency, inverted by the mask
    send_pkt(8, -1, 1'b1, 1'b1);
    check("lat_idle", 64'(o_axi_tx_tvalid), 64'd0);
    @(negedge clk);
    check("lat_first", 64'(o_axi_tx_tvalid), 64'd1);
    check("lat_data", o_axi_tx_tdata, 64'd0 ^ MASK);
    wait_drain("drain_single", 50);
    check_counts("single");

    // backpressure: fill the buffer, then drain and accept a fifth packet
    tx_mode = 0;
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) send_pkt(8, -1, 1'b1, 1'b0);
    check("full_tready", 64'(o_axi_rx_tready), 64'd0);
    check("stall_valid", 64'(o_axi_tx_tvalid), 64'd1);
    check("stall_data", o_axi_tx_tdata, exp_q[0]);
    @(negedge clk);
    check("stall_data2", o_axi_tx_tdata, exp_q[0]);
    tx_mode = 1;
    send_pkt(8, -1, 1'b1, 1'b0);
    wait_drain("drain_full", 300);
    check_counts("full");

    // framing errors: short, long, then good
    send_pkt(4, -1, 1'b1, 1'b0);
    send_pkt(10, -1, 1'b1, 1'b0);
    send_pkt(8, -1, 1'b1, 1'b0);
    wait_drain("drain_frame", 100);
    check_counts("frame");

    // bad tkeep on beat 2
    send_pkt(8, 2, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check_counts("badkeep");

    // flush during rx
    send_pkt(3, -1, 1'b0, 1'b0);
    i_stat_chan_up = 1'b0;
    #1;
    check("flush_rx_tready", 64'(o_axi_rx_tready), 64'd0);
    @(negedge clk);
    check("flush_rx_tvalid", 64'(o_axi_tx_tvalid), 64'd0);
    check_counts("flush_rx");
    i_stat_chan_up = 1'b1;
    send_pkt(8, -1, 1'b1, 1'b0);
    wait_drain("drain_after_flush_rx", 100);
    check_counts("after_flush_rx");

    // flush during tx with two packets buffered
    tx_mode = 0;
    @(negedge clk);
    send_pkt(8, -1, 1'b1, 1'b0);
    send_pkt(8, -1, 1'b1, 1'b0);
    tx_mode = 2;
    repeat (6) @(negedge clk);
    i_stat_chan_up = 1'b0;
    @(negedge clk);
    check("flush_tx_tvalid", 64'(o_axi_tx_tvalid), 64'd0);
    check("flush_tx_tready", 64'(o_axi_rx_tready), 64'd0);
    exp_q.delete();
    i_stat_chan_up = 1'b1;
    tx_mode = 1;
    repeat (30) @(negedge clk);
    check("flush_tx_empty", 64'(o_axi_tx_tvalid), 64'd0);
    check_counts("flush_tx");
    send_pkt(8, -1, 1'b1, 1'b0);
    wait_drain("drain_after_flush_tx", 100);

    // random mix of good and bad packets with random tx backpressure
    tx_mode = 2;
    for (int k = 0; k < 12; k++) begin
      kind = int'($urandom_range(0, 4));
      if (kind <= 1)      send_pkt(8, -1, 1'b1, 1'b0);
      else if (kind == 2) send_pkt(int'($urandom_range(1, 7)), -1, 1'b1, 1'b0);
      else if (kind == 3) send_pkt(int'($urandom_range(9, 12)), -1, 1'b1, 1'b0);
      else                send_pkt(8, int'($urandom_range(0, 7)), 1'b1, 1'b0);
    end
    wait_drain("drain_random", 2000);
    check_counts("random");

    // reset with two packets buffered
    tx_mode = 0;
    @(negedge clk);
    send_pkt(8, -1, 1'b1, 1'b0);
    send_pkt(8, -1, 1'b1, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_tvalid", 64'(o_axi_tx_tvalid), 64'd0);
    check("mrst_tdata", o_axi_tx_tdata, 64'd0);
    check("mrst_ctl", {55'd0, o_axi_tx_tkeep, o_axi_tx_tlast}, 64'd0);
    check("mrst_tready", 64'(o_axi_rx_tready), 64'd0);
    exp_q.delete();
    ok_m  = 0;
    err_m = 0;
    check_counts("mrst");
    reset_n = 1'b1;
    tx_mode = 1;
    repeat (40) @(negedge clk);
    check("mrst_no_stale", 64'(o_axi_tx_tvalid), 64'd0);
    send_pkt(8, -1, 1'b1, 1'b1);
    wait_drain("drain_after_rst", 100);
    check_counts("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
